// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive input sweeper and truth-table capture for a small combinational block (optional checker: SWEEP_CHECK_EN)
module truth_table_sweeper #(
    parameter int N_IN          = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   f_in,
`ifdef SWEEP_CHECK_EN
    input  logic [(2**N_IN)-1:0]   expected_in,
    output logic                   mismatch,
    output logic [N_IN-1:0]        fail_idx,
`endif
    output logic [N_IN-1:0]        vec_out,
    output logic                   busy,
    output logic                   done,
    output logic [(2**N_IN)-1:0]   table_out,
    output logic [N_IN:0]          ones_count
);

    localparam int N_VEC = 2 ** N_IN;
    // A settle time of one cycle still needs a one-bit counter to exist.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [N_IN-1:0]  LAST_VEC = N_IN'(N_VEC - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;

`ifdef SWEEP_CHECK_EN
    logic [N_VEC-1:0] expected_q;
`endif

    // Sweep sequencer: holds each vector for SETTLE_CYCLES, samples f_in on the last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            vec_out    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            table_out  <= '0;
            ones_count <= '0;
`ifdef SWEEP_CHECK_EN
            expected_q <= '0;
            mismatch   <= 1'b0;
            fail_idx   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    // abort has priority so a simultaneous start/abort is a no-op.
                    if (start && !abort) begin
                        state      <= S_RUN;
                        busy       <= 1'b1;
                        vec_out    <= '0;
                        settle_cnt <= '0;
                        table_out  <= '0;
                        ones_count <= '0;
`ifdef SWEEP_CHECK_EN
                        expected_q <= expected_in;
                        mismatch   <= 1'b0;
                        fail_idx   <= '0;
`endif
                    end
                end

                S_RUN: begin
                    if (abort) begin
                        // Partial table and count are deliberately kept for inspection.
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        vec_out    <= '0;
                        settle_cnt <= '0;
                    end else if (settle_cnt != CNT_LAST) begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end else begin
                        table_out[vec_out] <= f_in;
                        ones_count         <= ones_count + {{N_IN{1'b0}}, f_in};
                        settle_cnt         <= '0;
`ifdef SWEEP_CHECK_EN
                        if (f_in != expected_q[vec_out]) begin
                            mismatch <= 1'b1;
                            if (!mismatch) begin
                                fail_idx <= vec_out;
                            end
                        end
`endif
                        // The only wrap of vec_out back to 0 happens here, on sweep completion.
                        if (vec_out == LAST_VEC) begin
                            state   <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            vec_out <= '0;
                        end else begin
                            vec_out <= vec_out + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    // One-cycle completion pulse; start is not honoured here.
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    vec_out    <= '0;
                    settle_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - directed self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

    localparam int N_IN = 4;
    localparam int SETTLE_CYCLES = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        f_in;
    logic [3:0]  vec_out;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
    logic [4:0]  ones_count;
`ifdef SWEEP_CHECK_EN
    logic [15:0] expected_in;
    logic        mismatch;
    logic [3:0]  fail_idx;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    truth_table_sweeper #(
        .N_IN          (N_IN),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .f_in        (f_in),
`ifdef SWEEP_CHECK_EN
        .expected_in (expected_in),
        .mismatch    (mismatch),
        .fail_idx    (fail_idx),
`endif
        .vec_out     (vec_out),
        .busy        (busy),
        .done        (done),
        .table_out   (table_out),
        .ones_count  (ones_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lab block under test: f = (a & b) | (c & ~d), a = vec_out[3] ... d = vec_out[0].
    assign f_in = (vec_out[3] & vec_out[2]) | (vec_out[1] & ~vec_out[0]);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call right after the accepting edge; checks the 31 RUN cycles and the done edge.
    task automatic full_sweep(input string tag);
        for (int k = 1; k < 32; k++) begin
            step();
            check({tag, "_vec"}, {28'd0, vec_out}, k >> 1);
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_nodone"}, {31'd0, done}, 32'd0);
        end
        step();
        check({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_end_done"}, {31'd0, done}, 32'd1);
        check({tag, "_end_vec"}, {28'd0, vec_out}, 32'd0);
        check({tag, "_table"}, {16'd0, table_out}, 32'hF444);
        check({tag, "_ones"}, {27'd0, ones_count}, 32'd7);
    endtask

    task automatic wait_vec(input logic [3:0] v);
        int n = 0;
        while (vec_out !== v && n < 40) begin
            step();
            n++;
        end
        check("wait_vec_bound", {31'd0, (n < 40)}, 32'd1);
    endtask

    initial begin
        bit seen_done;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
`ifdef SWEEP_CHECK_EN
        expected_in = 16'h0000;
`endif
        step();
        step();
        check("reset_state", {5'd0, vec_out, busy, done, table_out, ones_count}, 32'd0);
        rst_n = 1'b1;

        // Idle with start low: everything stays at zero.
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_zero", {5'd0, vec_out, busy, done, table_out, ones_count}, 32'd0);
        end

        // start together with abort must not launch a sweep.
        start = 1'b1;
        abort = 1'b1;
        step();
        check("start_abort_idle", {31'd0, busy}, 32'd0);
        start = 1'b0;
        abort = 1'b0;
        step();

        // Single start pulse: full sweep, vectors ascending, two cycles each.
        start = 1'b1;
        step();
        start = 1'b0;
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("accept_vec", {28'd0, vec_out}, 32'd0);
        full_sweep("sweep1");
        step();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("table_hold", {16'd0, table_out}, 32'hF444);
        step();
        check("ones_hold", {27'd0, ones_count}, 32'd7);

        // start held high: back-to-back sweeps, re-accepted only from IDLE.
        start = 1'b1;
        step();
        check("held_accept", {31'd0, busy}, 32'd1);
        full_sweep("held1");
        step();
        check("held_gap_busy", {31'd0, busy}, 32'd0);
        check("held_gap_done", {31'd0, done}, 32'd0);
        step();
        check("held_restart", {31'd0, busy}, 32'd1);
        check("held_restart_table", {16'd0, table_out}, 32'd0);
        full_sweep("held2");
        start = 1'b0;
        step();
        step();

        // Abort once vector 6 has been sampled: partial table keeps bits 2 and 6.
        start = 1'b1;
        step();
        start = 1'b0;
        wait_vec(4'd7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_vec", {28'd0, vec_out}, 32'd0);
        check("abort_table", {16'd0, table_out}, 32'h0044);
        check("abort_ones", {27'd0, ones_count}, 32'd2);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen_done = 1'b1;
            step();
        end
        check("abort_no_done", {31'd0, seen_done}, 32'd0);

        // Asynchronous reset mid-cycle while vector 9 is applied.
        start = 1'b1;
        step();
        start = 1'b0;
        wait_vec(4'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {5'd0, vec_out, busy, done, table_out, ones_count}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        full_sweep("after_reset");
        step();

`ifdef SWEEP_CHECK_EN
        // Expected table wrong at index 2 only.
        expected_in = 16'hF440;
        start = 1'b1;
        step();
        start = 1'b0;
        expected_in = 16'h0000;
        full_sweep("chk_bad");
        check("chk_bad_mismatch", {31'd0, mismatch}, 32'd1);
        check("chk_bad_idx", {28'd0, fail_idx}, 32'd2);
        step();

        expected_in = 16'hF444;
        start = 1'b1;
        step();
        start = 1'b0;
        expected_in = 16'h0000;
        check("chk_clear", {31'd0, mismatch}, 32'd0);
        full_sweep("chk_good");
        check("chk_good_mismatch", {31'd0, mismatch}, 32'd0);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
